mem_port_arbiter: RTL and testbench

Round-robin arbiter that shares the single data port of the simulation ram among NUM_MASTERS requesters, for example the data ports of several riscv_core instances in a multi-core top. It uses the core's req/gnt/rvalid protocol on both sides: grant on accepted address phase, rvalid on the response phase. It tracks in-flight transfers in an ID FIFO so that each rvalid and its rdata go back to the originating master in order. It sits between the core data ports and ram data_* port.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_id_fifo.sv | 70 +++++++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   MAX_MASTERS    : largest supported number of requesters
//   BE_WIDTH       : byte-enable width of the data port
//   DATA_WIDTH     : data width of the data port
//   MAX_ADDR_WIDTH : widest address the mem_req_t container can carry
//   mem_req_t      : address-phase attributes routed through the request mux
//   next_index()   : round-robin successor of an index, modulo n
package mem_arb_pkg;

    localparam int MAX_MASTERS    = 8;
    localparam int BE_WIDTH       = 4;
    localparam int DATA_WIDTH     = 32;
    localparam int MAX_ADDR_WIDTH = 64;

    typedef struct packed {
        logic [MAX_ADDR_WIDTH-1:0] addr;
        logic                      we;
        logic [BE_WIDTH-1:0]       be;
        logic [DATA_WIDTH-1:0]     wdata;
    } mem_req_t;

    function automatic int next_index(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of master IDs for transfers that were accepted by memory
// but have not been answered yet.
//   clk_i, rst_i : clock, synchronous active-high reset (clears pointers/count)
//   push_i       : store push_id_i (ignored when full)
//   pop_i        : drop the head entry (ignored when empty)
//   head_o       : ID of the oldest outstanding transfer
//   count_o      : number of stored IDs, 0..DEPTH
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
module mem_arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int IDW   = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [IDW-1:0]             push_id_i,
    input  logic                       pop_i,
    output logic [IDW-1:0]             head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [IDW-1:0] mem_q [DEPTH];
    logic [IDW-1:0] mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_push  = push_i & ~full_o;
        do_pop   = pop_i & ~empty_o;
        // Pointers wrap explicitly so DEPTH need not be a power of two.
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id_i;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory data port among NUM_MASTERS
// requesters, with in-order routing of responses back to their masters.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   m_req_i .. m_wdata_i: per-master address phase
//   m_gnt_o             : one-hot grant, combinational from mem_gnt_i
//   m_rvalid_o          : one-hot response valid, routed by the ID FIFO head
//   m_rdata_o           : mem_rdata_i broadcast to all masters
//   mem_*_o / mem_*_i   : memory side of the same protocol
//   err_o               : sticky, set by a response with nothing outstanding
//
// Handshake: an address phase is transferred in the cycle where req and gnt
// are both high; the requester must hold req and its attributes until then.
// A response is a single-cycle rvalid pulse, strictly in acceptance order,
// no earlier than the cycle after the matching grant.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_MASTERS-1:0]                m_req_i,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS-1:0]                m_we_i,
    input  logic [NUM_MASTERS-1:0][BE_WIDTH-1:0]  m_be_i,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata_i,
    output logic [NUM_MASTERS-1:0]                m_gnt_o,
    output logic [NUM_MASTERS-1:0]                m_rvalid_o,
    output logic [DATA_WIDTH-1:0]                 m_rdata_o,
    output logic                                  mem_req_o,
    output logic [ADDR_WIDTH-1:0]                 mem_addr_o,
    output logic                                  mem_we_o,
    output logic [BE_WIDTH-1:0]                   mem_be_o,
    output logic [DATA_WIDTH-1:0]                 mem_wdata_o,
    input  logic                                  mem_gnt_i,
    input  logic                                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata_i,
    output logic                                  err_o
);

    localparam int IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

    logic [IDW-1:0] prio_q, prio_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;
    logic           lock_q, lock_d;
    logic           err_q, err_d;

    logic [IDW-1:0] winner;
    logic [IDW-1:0] cand;
    logic           found;
    logic           any_req;
    logic           lock_valid;
    logic           accept;
    logic           pop;
    logic [IDW-1:0] head_id;
    logic [CW-1:0]  count;
    logic           fifo_full;
    logic           fifo_empty;
    mem_req_t       sel;

    assign any_req = |m_req_i;

    // A lock only counts while its master still requests; if the master
    // withdraws, normal round-robin takes over in the same cycle.
    assign lock_valid = lock_q & m_req_i[lock_id_q];

    always_comb begin
        winner = prio_q;
        found  = 1'b0;
        cand   = '0;
        if (lock_valid) begin
            winner = lock_id_q;
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                cand = IDW'((int'(prio_q) + i) % NUM_MASTERS);
                if (!found && m_req_i[cand]) begin
                    winner = cand;
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel = '0;
        if (any_req) begin
            sel.addr  = MAX_ADDR_WIDTH'(m_addr_i[winner]);
            sel.we    = m_we_i[winner];
            sel.be    = m_be_i[winner];
            sel.wdata = m_wdata_i[winner];
        end
    end

    assign mem_addr_o  = sel.addr[ADDR_WIDTH-1:0];
    assign mem_we_o    = sel.we;
    assign mem_be_o    = sel.be;
    assign mem_wdata_o = sel.wdata;

    // Capacity is checked against the registered count only: a response in
    // the same cycle frees a slot for the next cycle, not this one.
    assign mem_req_o = any_req & ~fifo_full & ~rst_i;
    assign accept    = mem_req_o & mem_gnt_i;
    assign pop       = mem_rvalid_i & ~fifo_empty & ~rst_i;
    assign m_rdata_o = mem_rdata_i;
    assign err_o     = err_q;

    always_comb begin
        m_gnt_o = '0;
        if (accept) m_gnt_o[winner] = 1'b1;
    end

    always_comb begin
        m_rvalid_o = '0;
        if (pop) m_rvalid_o[head_id] = 1'b1;
    end

    always_comb begin
        prio_d    = prio_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        err_d     = err_q | (mem_rvalid_i & (count == '0));
        if (accept) begin
            prio_d = IDW'(next_index(int'(winner), NUM_MASTERS));
            lock_d = 1'b0;
        end else if (mem_req_o) begin
            // Stalled by memory: pin this master until it is accepted.
            lock_d    = 1'b1;
            lock_id_d = winner;
        end else begin
            lock_d = lock_valid;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q    <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            prio_q    <= prio_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
        end
    end

    mem_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .IDW   (IDW)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (accept),
        .push_id_i (winner),
        .pop_i     (pop),
        .head_o    (head_id),
        .count_o   (count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a queue-based model of the arbiter.
module tb_mem_port_arbiter;

    localparam int N    = 2;
    localparam int AW   = 32;
    localparam int MAXO = 2;

    logic                  clk_i;
    logic                  rst_i;
    logic [N-1:0]          m_req_i;
    logic [N-1:0][AW-1:0]  m_addr_i;
    logic [N-1:0]          m_we_i;
    logic [N-1:0][3:0]     m_be_i;
    logic [N-1:0][31:0]    m_wdata_i;
    logic [N-1:0]          m_gnt_o;
    logic [N-1:0]          m_rvalid_o;
    logic [31:0]           m_rdata_o;
    logic                  mem_req_o;
    logic [AW-1:0]         mem_addr_o;
    logic                  mem_we_o;
    logic [3:0]            mem_be_o;
    logic [31:0]           mem_wdata_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [31:0]           mem_rdata_i;
    logic                  err_o;

    mem_port_arbiter #(
        .NUM_MASTERS     (N),
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (MAXO)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .m_req_i      (m_req_i),
        .m_addr_i     (m_addr_i),
        .m_we_i       (m_we_i),
        .m_be_i       (m_be_i),
        .m_wdata_i    (m_wdata_i),
        .m_gnt_o      (m_gnt_o),
        .m_rvalid_o   (m_rvalid_o),
        .m_rdata_o    (m_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .err_o        (err_o)
    );

    // ---------------- clock ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int outstanding_q[$];   // master IDs in acceptance order
    int resp_due_q[$];      // cycles at which the memory answers
    int m_prio    = 0;
    bit m_lock    = 0;
    int m_lock_id = 0;
    bit m_err     = 0;
    bit auto_resp = 0;
    bit rand_resp = 0;
    int lat       = 1;

    task automatic step();
        int  n;
        bit  any_req, lockv, exp_req, acc, pop;
        int  win;
        logic [N-1:0] exp_gnt, exp_rv;
        logic [AW-1:0] exp_addr;
        logic [36:0] exp_attr;

        if (auto_resp) begin
            mem_rvalid_i = (resp_due_q.size() > 0) && (resp_due_q[0] <= cyc);
            if (mem_rvalid_i) resp_due_q.delete(0);
        end else if (rand_resp) begin
            mem_rvalid_i = (outstanding_q.size() > 0) ? ($urandom_range(0, 2) == 0)
                                                      : ($urandom_range(0, 15) == 0);
        end

        @(negedge clk_i);
        n       = outstanding_q.size();
        any_req = |m_req_i;
        lockv   = m_lock && m_req_i[m_lock_id];
        win     = 0;
        if (lockv) win = m_lock_id;
        else begin
            for (int k = 0; k < N; k++) begin
                if (m_req_i[(m_prio + k) % N]) begin
                    win = (m_prio + k) % N;
                    break;
                end
            end
        end
        exp_req = any_req && (n < MAXO) && !rst_i;
        acc     = exp_req && mem_gnt_i;
        pop     = mem_rvalid_i && (n > 0) && !rst_i;
        exp_gnt = '0;
        if (acc) exp_gnt[win] = 1'b1;
        exp_rv = '0;
        if (pop) exp_rv[outstanding_q[0]] = 1'b1;
        exp_addr = any_req ? m_addr_i[win] : '0;
        exp_attr = any_req ? {m_we_i[win], m_be_i[win], m_wdata_i[win]} : '0;

        check("mem_req", mem_req_o, exp_req);
        check("gnt", m_gnt_o, exp_gnt);
        check("rvalid", m_rvalid_o, exp_rv);
        check("addr", mem_addr_o, exp_addr);
        check("attr", {mem_we_o, mem_be_o, mem_wdata_o}, exp_attr);
        check("rdata", m_rdata_o, mem_rdata_i);
        check("err", err_o, m_err);
        check("count", u_dut.count, n);
        check("prio", u_dut.prio_q, m_prio);

        if (rst_i) begin
            outstanding_q.delete();
            resp_due_q.delete();
            m_prio = 0;
            m_lock = 0;
            m_err  = 0;
        end else begin
            if (mem_rvalid_i && n == 0) m_err = 1;
            if (pop) outstanding_q.delete(0);
            if (acc) begin
                outstanding_q.push_back(win);
                m_prio = (win + 1) % N;
                if (auto_resp) resp_due_q.push_back(cyc + lat);
            end
            if (acc) m_lock = 0;
            else if (exp_req) begin
                m_lock    = 1;
                m_lock_id = win;
            end else m_lock = lockv;
        end

        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic randomize_attrs();
        for (int i = 0; i < N; i++) begin
            m_addr_i[i]  = $urandom;
            m_we_i[i]    = 1'($urandom_range(0, 1));
            m_be_i[i]    = 4'($urandom_range(0, 15));
            m_wdata_i[i] = $urandom;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_i        = 1'b1;
        m_req_i      = '0;
        m_addr_i     = '0;
        m_we_i       = '0;
        m_be_i       = '0;
        m_wdata_i    = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        @(posedge clk_i);
        #1;

        // Reset state: requests and responses are blocked while in reset.
        m_req_i      = 2'b11;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        step();
        mem_rvalid_i = 1'b0;
        m_req_i      = '0;
        step();
        rst_i = 1'b0;

        // Single read from master 0, memory answers next cycle.
        auto_resp   = 1;
        lat         = 1;
        mem_rdata_i = 32'hDEADBEEF;
        m_addr_i[0] = 32'h100;
        m_req_i     = 2'b01;
        step();
        m_req_i = '0;
        step();
        check("single_rdata", m_rdata_o, 32'hDEADBEEF);
        step();

        // Both masters continuously: alternating grants and responses.
        m_addr_i[0] = 32'h1000;
        m_addr_i[1] = 32'h2000;
        m_req_i     = 2'b11;
        for (int i = 0; i < 8; i++) begin
            mem_rdata_i = $urandom;
            step();
        end
        m_req_i = '0;
        repeat (3) step();

        // Memory stalls master 1 while master 0 joins: lock holds master 1.
        mem_gnt_i = 1'b0;
        m_req_i   = 2'b10;
        step();
        m_req_i = 2'b11;
        step();
        step();
        mem_gnt_i = 1'b1;
        step();
        m_req_i = 2'b01;
        step();
        m_req_i = '0;
        repeat (3) step();

        // Slow memory: capacity limit and response/request in the same cycle.
        lat     = 4;
        m_req_i = 2'b11;
        repeat (14) step();
        m_req_i = '0;
        repeat (6) step();

        // Spurious response, then reset with two transfers in flight.
        auto_resp    = 0;
        mem_rvalid_i = 1'b1;
        step();
        mem_rvalid_i = 1'b0;
        repeat (2) step();
        m_req_i = 2'b11;
        repeat (2) step();
        m_req_i = '0;
        rst_i   = 1'b1;
        step();
        rst_i = 1'b0;
        repeat (2) step();

        // Random traffic, including withdrawn requests and rare resets.
        rand_resp = 1;
        for (int i = 0; i < 500; i++) begin
            m_req_i     = N'($urandom_range(0, (1 << N) - 1));
            mem_gnt_i   = ($urandom_range(0, 3) != 0);
            mem_rdata_i = $urandom;
            rst_i       = ($urandom_range(0, 99) == 0);
            randomize_attrs();
            step();
        end
        rst_i        = 1'b0;
        m_req_i      = '0;
        rand_resp    = 0;
        mem_rvalid_i = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
